// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath width, branch funct3 and writeback-select encodings
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

endpackage

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - combinational branch condition from subtract-compare flags
module branch_cond
  import riscv_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       v_i,
  input  logic       c_i,
  input  logic       n_i,
  input  logic       z_i,
  output logic       cond_o
);

  // C is a borrow flag, so C=1 means A<B unsigned.
  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond_o = z_i;
      F3_BNE:  cond_o = ~z_i;
      F3_BLT:  cond_o = n_i ^ v_i;
      F3_BGE:  cond_o = ~(n_i ^ v_i);
      F3_BLTU: cond_o = c_i;
      F3_BGEU: cond_o = ~c_i;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/M pipeline register with branch resolution and redirect counter
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_m,
  input  logic            flush_m,
  input  logic            valid_e,
  input  logic [XLEN-1:0] alu_result_e,
  input  logic            V_e,
  input  logic            C_e,
  input  logic            N_e,
  input  logic            Z_e,
  input  logic [XLEN-1:0] write_data_e,
  input  logic [4:0]      rd_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic            branch_e,
  input  logic            jump_e,
  input  logic [2:0]      funct3_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic [1:0]      result_src_e,
  output logic            pc_src_e,
  output logic            valid_m,
  output logic [XLEN-1:0] alu_result_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [4:0]      rd_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [2:0]      funct3_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic [1:0]      result_src_m,
  output logic [31:0]     redirect_count
);

  logic            cond;
  logic            valid_q,      valid_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [4:0]      rd_q,         rd_d;
  logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
  logic [2:0]      funct3_q,     funct3_d;
  logic            reg_write_q,  reg_write_d;
  logic            mem_write_q,  mem_write_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [31:0]     redirect_count_q, redirect_count_d;

  branch_cond u_branch_cond (
    .funct3_i (funct3_e),
    .v_i      (V_e),
    .c_i      (C_e),
    .n_i      (N_e),
    .z_i      (Z_e),
    .cond_o   (cond)
  );

  assign pc_src_e = valid_e & ~flush_m & (jump_e | (branch_e & cond));

  // Flush wins over stall; a stall holds everything including the counter,
  // so a stalled redirect is counted only on the edge it finally advances.
  always_comb begin
    valid_d          = valid_q;
    alu_result_d     = alu_result_q;
    write_data_d     = write_data_q;
    rd_d             = rd_q;
    pc_plus4_d       = pc_plus4_q;
    funct3_d         = funct3_q;
    reg_write_d      = reg_write_q;
    mem_write_d      = mem_write_q;
    result_src_d     = result_src_q;
    redirect_count_d = redirect_count_q;
    if (flush_m) begin
      valid_d      = 1'b0;
      alu_result_d = '0;
      write_data_d = '0;
      rd_d         = '0;
      pc_plus4_d   = '0;
      funct3_d     = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      result_src_d = '0;
    end else if (!stall_m) begin
      valid_d      = valid_e;
      alu_result_d = alu_result_e;
      write_data_d = write_data_e;
      rd_d         = rd_e;
      pc_plus4_d   = pc_plus4_e;
      funct3_d     = funct3_e;
      reg_write_d  = reg_write_e & valid_e;
      mem_write_d  = mem_write_e & valid_e;
      result_src_d = result_src_e;
      if (pc_src_e) redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q          <= 1'b0;
      alu_result_q     <= '0;
      write_data_q     <= '0;
      rd_q             <= '0;
      pc_plus4_q       <= '0;
      funct3_q         <= '0;
      reg_write_q      <= 1'b0;
      mem_write_q      <= 1'b0;
      result_src_q     <= '0;
      redirect_count_q <= '0;
    end else begin
      valid_q          <= valid_d;
      alu_result_q     <= alu_result_d;
      write_data_q     <= write_data_d;
      rd_q             <= rd_d;
      pc_plus4_q       <= pc_plus4_d;
      funct3_q         <= funct3_d;
      reg_write_q      <= reg_write_d;
      mem_write_q      <= mem_write_d;
      result_src_q     <= result_src_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign valid_m        = valid_q;
  assign alu_result_m   = alu_result_q;
  assign write_data_m   = write_data_q;
  assign rd_m           = rd_q;
  assign pc_plus4_m     = pc_plus4_q;
  assign funct3_m       = funct3_q;
  assign reg_write_m    = reg_write_q;
  assign mem_write_m    = mem_write_q;
  assign result_src_m   = result_src_q;
  assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed self-checking bench for ex_mem_stage
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset, stall_m, flush_m, valid_e;
  logic [31:0] alu_result_e, write_data_e, pc_plus4_e;
  logic        V_e, C_e, N_e, Z_e;
  logic [4:0]  rd_e;
  logic        branch_e, jump_e, reg_write_e, mem_write_e;
  logic [2:0]  funct3_e;
  logic [1:0]  result_src_e;
  logic        pc_src_e, valid_m, reg_write_m, mem_write_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m, redirect_count;
  logic [4:0]  rd_m;
  logic [2:0]  funct3_m;
  logic [1:0]  result_src_m;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .stall_m(stall_m), .flush_m(flush_m),
    .valid_e(valid_e), .alu_result_e(alu_result_e),
    .V_e(V_e), .C_e(C_e), .N_e(N_e), .Z_e(Z_e),
    .write_data_e(write_data_e), .rd_e(rd_e), .pc_plus4_e(pc_plus4_e),
    .branch_e(branch_e), .jump_e(jump_e), .funct3_e(funct3_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .result_src_e(result_src_e), .pc_src_e(pc_src_e),
    .valid_m(valid_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .rd_m(rd_m), .pc_plus4_m(pc_plus4_m), .funct3_m(funct3_m),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .redirect_count(redirect_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall_m = 1'b0; flush_m = 1'b0; valid_e = 1'b0;
    alu_result_e = '0; write_data_e = '0; pc_plus4_e = '0;
    V_e = 0; C_e = 0; N_e = 0; Z_e = 0; rd_e = '0;
    branch_e = 0; jump_e = 0; reg_write_e = 0; mem_write_e = 0;
    funct3_e = '0; result_src_e = '0;
    tick();
    tick();

    // reset state and pc_src_e live during reset
    chk("rst_valid_m", {31'd0, valid_m}, 32'd0);
    chk("rst_alu_m", alu_result_m, 32'd0);
    chk("rst_count", redirect_count, 32'd0);
    valid_e = 1; jump_e = 1; reg_write_e = 1; alu_result_e = 32'h77;
    #1;
    chk("rst_pc_src", {31'd0, pc_src_e}, 32'd1);
    tick();
    chk("rst_count_hold0", redirect_count, 32'd0);
    chk("rst_regw_m", {31'd0, reg_write_m}, 32'd0);
    reset = 0; jump_e = 0;

    // beq taken
    branch_e = 1; funct3_e = 3'b000; Z_e = 1;
    alu_result_e = 32'hAA; rd_e = 5'd3; write_data_e = 32'hDEAD;
    pc_plus4_e = 32'h104; result_src_e = 2'b10;
    #1;
    chk("beq_pc_src", {31'd0, pc_src_e}, 32'd1);
    tick();
    chk("beq_count", redirect_count, 32'd1);
    chk("beq_valid_m", {31'd0, valid_m}, 32'd1);
    chk("beq_alu_m", alu_result_m, 32'hAA);
    chk("beq_rd_m", {27'd0, rd_m}, 32'd3);
    chk("beq_wdata_m", write_data_m, 32'hDEAD);
    chk("beq_pc4_m", pc_plus4_m, 32'h104);
    chk("beq_rsrc_m", {30'd0, result_src_m}, 32'd2);
    chk("beq_regw_m", {31'd0, reg_write_m}, 32'd1);

    // condition decode, combinational only
    Z_e = 0; #1;
    chk("beq_nt", {31'd0, pc_src_e}, 32'd0);
    funct3_e = 3'b001; #1;
    chk("bne_t", {31'd0, pc_src_e}, 32'd1);
    funct3_e = 3'b100; N_e = 1; V_e = 1; #1;
    chk("blt_nv", {31'd0, pc_src_e}, 32'd0);
    funct3_e = 3'b101; V_e = 0; #1;
    chk("bge_n", {31'd0, pc_src_e}, 32'd0);
    funct3_e = 3'b110; N_e = 0; C_e = 1; #1;
    chk("bltu_c", {31'd0, pc_src_e}, 32'd1);
    funct3_e = 3'b111; #1;
    chk("bgeu_c", {31'd0, pc_src_e}, 32'd0);
    funct3_e = 3'b010; Z_e = 1; #1;
    chk("f3_010", {31'd0, pc_src_e}, 32'd0);
    valid_e = 0; funct3_e = 3'b110; #1;
    chk("invalid_nt", {31'd0, pc_src_e}, 32'd0);
    valid_e = 1; branch_e = 0; C_e = 0; Z_e = 0;

    // stall holds captured instruction; stalled jump counts once
    alu_result_e = 32'h1234; rd_e = 5'd5; reg_write_e = 1; funct3_e = 3'b010;
    tick();
    chk("stl_load_alu", alu_result_m, 32'h1234);
    chk("stl_load_f3", {29'd0, funct3_m}, 32'd2);
    stall_m = 1; jump_e = 1;
    for (int i = 0; i < 3; i++) begin
      alu_result_e = 32'hFFFF + i; rd_e = 5'd9 + i[4:0];
      tick();
      chk("stl_alu_hold", alu_result_m, 32'h1234);
      chk("stl_rd_hold", {27'd0, rd_m}, 32'd5);
      chk("stl_cnt_hold", redirect_count, 32'd1);
    end
    stall_m = 0;
    tick();
    chk("stl_release_cnt", redirect_count, 32'd2);
    chk("stl_release_alu", alu_result_m, 32'h10001);
    chk("stl_release_rd", {27'd0, rd_m}, 32'd11);
    jump_e = 0;

    // store enable passes; invalid capture forces enables low
    mem_write_e = 1;
    tick();
    chk("st_memw_m", {31'd0, mem_write_m}, 32'd1);
    valid_e = 0; alu_result_e = 32'h99;
    tick();
    chk("inv_valid_m", {31'd0, valid_m}, 32'd0);
    chk("inv_regw_m", {31'd0, reg_write_m}, 32'd0);
    chk("inv_memw_m", {31'd0, mem_write_m}, 32'd0);
    chk("inv_alu_m", alu_result_m, 32'h99);

    // stall and flush together: bubble, no count
    valid_e = 1; reg_write_e = 1; jump_e = 1; stall_m = 1; flush_m = 1;
    #1;
    chk("fl_pc_src", {31'd0, pc_src_e}, 32'd0);
    tick();
    chk("fl_valid_m", {31'd0, valid_m}, 32'd0);
    chk("fl_regw_m", {31'd0, reg_write_m}, 32'd0);
    chk("fl_alu_m", alu_result_m, 32'd0);
    chk("fl_cnt", redirect_count, 32'd2);
    stall_m = 0; flush_m = 0;

    // counter wrap after preloading near the top
    dut.redirect_count_q = 32'hFFFF_FFFE;
    tick();
    chk("wrap_ff", redirect_count, 32'hFFFF_FFFF);
    tick();
    chk("wrap_zero", redirect_count, 32'd0);
    tick();
    chk("wrap_one", redirect_count, 32'd1);

    // reset mid-stall discards held instruction
    alu_result_e = 32'hABC; stall_m = 1; flush_m = 1; reset = 1;
    tick();
    chk("rs_valid_m", {31'd0, valid_m}, 32'd0);
    chk("rs_alu_m", alu_result_m, 32'd0);
    chk("rs_count", redirect_count, 32'd0);
    chk("rs_pc4_m", pc_plus4_m, 32'd0);
    reset = 0; flush_m = 0; stall_m = 0; jump_e = 0;
    alu_result_e = 32'h55; rd_e = 5'd7;
    tick();
    chk("post_rs_alu", alu_result_m, 32'h55);
    chk("post_rs_rd", {27'd0, rd_m}, 32'd7);
    chk("post_rs_valid", {31'd0, valid_m}, 32'd1);
    chk("post_rs_cnt", redirect_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall_m  input  1  hold all M-stage registers.
REQ-005 SHALL have port flush_m  input  1  load a bubble into the M stage.
REQ-006 SHALL have port valid_e  input  1  EX holds a real instruction.
REQ-007 SHALL have port alu_result_e  input  XLEN  ALU result.
REQ-008 SHALL have port V_e, C_e, N_e, Z_e  input  1 each  ALU flags from a subtract compare (C=1 means borrow, i.e. A<B unsigned).
REQ-009 SHALL have port write_data_e  input  XLEN  forwarded rs2 store data.
REQ-010 SHALL have port rd_e  input  5  destination register.
REQ-011 SHALL have port pc_plus4_e  input  XLEN  link value.
REQ-012 SHALL have port branch_e, jump_e  input  1 each  conditional branch / unconditional jump.
REQ-013 SHALL have port funct3_e  input  3  branch condition or load/store width.
REQ-014 SHALL have port reg_write_e, mem_write_e  input  1 each  write enables.
REQ-015 SHALL have port result_src_e  input  2  writeback select.
REQ-016 SHALL have port pc_src_e  output  1  combinational redirect request to fetch.
REQ-017 SHALL have ports valid_m, alu_result_m, write_data_m, rd_m, pc_plus4_m, funct3_m, reg_write_m, mem_write_m, result_src_m  output  widths as EX counterparts  registered M-stage copies.
REQ-018 SHALL have port redirect_count  output  32  count of retired redirects.

Function
REQ-019 Condition SHALL decode funct3_e: 000 Z; 001 !Z; 100 N^V; 101 !(N^V); 110 C; 111 !C; 010/011 false.
REQ-020 pc_src_e SHALL equal valid_e & !flush_m & (jump_e | (branch_e & condition)), zero latency.
REQ-021 On clock edge with !reset, !stall_m, !flush_m: every *_m register SHALL load its *_e value; valid_m=valid_e.
REQ-022 On edge with flush_m=1 (any stall_m): valid_m, reg_write_m, mem_write_m SHALL become 0; data fields SHALL become 0.
REQ-023 On edge with stall_m=1, flush_m=0: all *_m registers and redirect_count SHALL hold.
REQ-024 When valid_e=0 is captured, reg_write_m and mem_write_m SHALL be forced to 0.
REQ-025 redirect_count SHALL increment by 1 on an edge where pc_src_e=1, stall_m=0, flush_m=0; wraps 0xFFFFFFFF->0.
REQ-026 A stall lasting N cycles SHALL produce exactly one increment for the stalled instruction.
REQ-027 No combinational path SHALL exist from any input to any *_m output or redirect_count.

Reset
REQ-028 reset=1 at an edge SHALL clear every *_m output and redirect_count to 0, overriding stall_m and flush_m.
REQ-029 Reset asserted mid-stall SHALL discard the held instruction; first post-reset capture SHALL follow REQ-021.
REQ-030 pc_src_e SHALL remain a function of current inputs during reset.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the funct3 branch encodings, result_src encodings and XLEN.
REQ-032 The flag-to-condition decode SHALL be one combinational sub-module, branch_cond; all registers live in ex_mem_stage.

Verification
REQ-033 beq, Z_e=1, valid_e=1, branch_e=1 -> pc_src_e=1 same cycle; next edge redirect_count=1, valid_m=1.
REQ-034 blt with N_e=1, V_e=1 -> pc_src_e=0; bltu with C_e=1 -> pc_src_e=1; funct3=010, branch_e=1 -> pc_src_e=0.
REQ-035 alu_result_e=0x0000_1234, rd_e=5, reg_write_e=1, then stall_m=1 for 3 cycles with changing inputs -> alu_result_m stays 0x1234, rd_m stays 5.
REQ-036 stall_m=1 and flush_m=1 together with reg_write_e=1 -> next edge valid_m=0, reg_write_m=0, no count.
REQ-037 Jump captured with redirect_count preloaded to 0xFFFFFFFF via repeated jumps -> wraps to 0; then reset=1 -> all outputs 0.
